// File: rtl/bram_slave_split_if.sv
// Serial bus lanes between the interconnect slave port and a block-RAM slave.
// All data/address/burst lanes are one bit wide and carried LSB first.
interface bram_slave_split_if;
  logic [5:0] slave_delay;
  logic       read_en;
  logic       write_en;
  logic       master_valid;
  logic       master_ready;
  logic       rx_address;
  logic       rx_data;
  logic       rx_burst;
  logic       slave_ready;
  logic       slave_valid;
  logic       tx_data;
  logic       split_en;
  logic       busy;

  modport master (
    output slave_delay, read_en, write_en, master_valid, master_ready,
           rx_address, rx_data, rx_burst,
    input  slave_ready, slave_valid, tx_data, split_en, busy
  );

  modport slave (
    input  slave_delay, read_en, write_en, master_valid, master_ready,
           rx_address, rx_data, rx_burst,
    output slave_ready, slave_valid, tx_data, split_en, busy
  );
endinterface

// File: rtl/bram_slave_split.sv
// Block-RAM bus slave with serial address/data/burst lanes, wrapping bursts,
// programmable read delay and split signalling during long read waits.
module bram_slave_split #(
  parameter int ADDR_LEN        = 12,
  parameter int DATA_LEN        = 8,
  parameter int BURST_LEN       = 12,
  parameter int MEM_DEPTH       = 4096,
  parameter bit SPLIT_EN        = 1'b1,
  parameter int SPLIT_THRESHOLD = 8
) (
  input logic               clk,
  input logic               reset,
  bram_slave_split_if.slave bus
);

  localparam int AW      = $clog2(MEM_DEPTH);
  localparam int CNT_MAX = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]        ADDR_LAST  = CW'(ADDR_LEN - 1);
  localparam logic [CW-1:0]        DATA_LAST  = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0]        BURST_BITS = CW'(BURST_LEN);
  localparam logic [5:0]           SPLIT_MIN  = 6'(SPLIT_THRESHOLD);
  localparam logic [BURST_LEN-1:0] ONE_WORD   = BURST_LEN'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WAIT, S_RFETCH, S_RDATA
  } state_t;

  state_t state, state_nx;

  logic [DATA_LEN-1:0]  mem [MEM_DEPTH];
  logic [ADDR_LEN-1:0]  addr_sr;
  logic [BURST_LEN-1:0] burst_sr;
  logic [BURST_LEN-1:0] words_left;
  logic [AW-1:0]        ptr;
  logic [CW-1:0]        bit_cnt;
  logic [5:0]           delay_cnt;
  logic [DATA_LEN-1:0]  data_sr;
  logic                 is_wr;
  logic                 split_q;

  logic                 start, abort, addr_done, wr_done, rd_done, last_word, mem_we;
  logic [ADDR_LEN-1:0]  addr_full;
  logic [BURST_LEN-1:0] burst_full, burst_cnt;
  logic [DATA_LEN-1:0]  wr_word;

  // Exactly one of read_en/write_en opens a transaction; neither aborts one.
  assign start      = bus.master_valid && (bus.read_en ^ bus.write_en);
  assign abort      = !bus.read_en && !bus.write_en;
  assign addr_full  = {bus.rx_address, addr_sr[ADDR_LEN-1:1]};
  assign burst_full = (bit_cnt < BURST_BITS) ? {bus.rx_burst, burst_sr[BURST_LEN-1:1]} : burst_sr;
  assign burst_cnt  = (burst_full == '0) ? ONE_WORD : burst_full;
  assign wr_word    = {bus.rx_data, data_sr[DATA_LEN-1:1]};
  assign addr_done  = (state == S_ADDR)  && bus.master_valid && (bit_cnt == ADDR_LAST);
  assign wr_done    = (state == S_WDATA) && bus.master_valid && (bit_cnt == DATA_LAST);
  assign rd_done    = (state == S_RDATA) && bus.master_ready && (bit_cnt == DATA_LAST);
  assign last_word  = (words_left == ONE_WORD);
  assign mem_we     = wr_done && !abort && !reset;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: defaulting every always_comb output before the case keeps
    // unlisted paths from inferring latches.
    state_nx = state;
    if (state != S_IDLE && abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nx = S_ADDR;
        S_ADDR:   if (addr_done) state_nx = is_wr ? S_WDATA : S_WAIT;
        S_WDATA:  if (wr_done && last_word) state_nx = S_IDLE;
        S_WAIT:   if (delay_cnt == '0) state_nx = S_RFETCH;
        S_RFETCH: state_nx = S_RDATA;
        S_RDATA:  if (rd_done) state_nx = last_word ? S_IDLE : S_RFETCH;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.slave_ready = 1'b0;
    bus.slave_valid = 1'b0;
    bus.tx_data     = 1'b0;
    bus.split_en    = 1'b0;
    bus.busy        = (state != S_IDLE);
    case (state)
      S_IDLE, S_ADDR, S_WDATA: bus.slave_ready = 1'b1;
      S_WAIT:  bus.split_en = split_q;
      S_RDATA: begin
        bus.slave_valid = 1'b1;
        bus.tx_data     = data_sr[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_sr    <= '0;
      burst_sr   <= '0;
      words_left <= '0;
      ptr        <= '0;
      bit_cnt    <= '0;
      delay_cnt  <= '0;
      data_sr    <= '0;
      is_wr      <= 1'b0;
      split_q    <= 1'b0;
    end else if (state != S_IDLE && abort) begin
      bit_cnt <= '0;
      split_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          addr_sr  <= addr_full;
          burst_sr <= {bus.rx_burst, burst_sr[BURST_LEN-1:1]};
          bit_cnt  <= CW'(1);
          is_wr    <= bus.write_en;
        end
        S_ADDR: if (bus.master_valid) begin
          addr_sr  <= addr_full;
          burst_sr <= burst_full;
          bit_cnt  <= bit_cnt + 1'b1;
          if (addr_done) begin
            // Delay and split decision are frozen at entry to the wait.
            ptr        <= addr_full[AW-1:0];
            words_left <= burst_cnt;
            bit_cnt    <= '0;
            delay_cnt  <= bus.slave_delay;
            split_q    <= SPLIT_EN && (bus.slave_delay >= SPLIT_MIN);
          end
        end
        S_WDATA: if (bus.master_valid) begin
          data_sr <= wr_word;
          bit_cnt <= bit_cnt + 1'b1;
          if (wr_done) begin
            bit_cnt    <= '0;
            ptr        <= ptr + 1'b1;
            words_left <= words_left - 1'b1;
          end
        end
        S_WAIT: if (delay_cnt != '0) delay_cnt <= delay_cnt - 1'b1;
        S_RFETCH: begin
          data_sr <= mem[ptr];
          bit_cnt <= '0;
        end
        S_RDATA: if (bus.master_ready) begin
          data_sr <= data_sr >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (rd_done) begin
            bit_cnt    <= '0;
            ptr        <= ptr + 1'b1;
            words_left <= words_left - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the memory array has no reset; contents survive reset and the
  // array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= wr_word;
  end

endmodule

// File: tb/tb_bram_slave_split.sv
// Randomized self-checking bench for bram_slave_split against a word-level
// memory model and timing rules computed from the transaction parameters.
module tb_bram_slave_split;
  localparam int ADDR_LEN  = 12;
  localparam int DATA_LEN  = 8;
  localparam int BURST_LEN = 12;
  localparam int DEPTH     = 4096;
  localparam int SPLIT_TH  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bram_slave_split_if bus ();

  bram_slave_split #(
    .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN), .BURST_LEN(BURST_LEN),
    .MEM_DEPTH(DEPTH), .SPLIT_EN(1'b1), .SPLIT_THRESHOLD(SPLIT_TH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] model [DEPTH];
  logic [7:0] wbuf  [8];
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.slave_delay  = '0;
    bus.read_en      = 1'b0;
    bus.write_en     = 1'b0;
    bus.master_valid = 1'b0;
    bus.master_ready = 1'b0;
    bus.rx_address   = 1'b0;
    bus.rx_data      = 1'b0;
    bus.rx_burst     = 1'b0;
  endtask

  task automatic send_header(input logic wr, input logic [11:0] addr,
                             input logic [11:0] burst, input bit stall);
    bus.write_en = wr;
    bus.read_en  = !wr;
    for (int i = 0; i < ADDR_LEN; i++) begin
      if (stall && $urandom_range(0, 3) == 0) begin
        bus.master_valid = 1'b0;
        tick();
      end
      bus.master_valid = 1'b1;
      bus.rx_address   = addr[i];
      bus.rx_burst     = (i < BURST_LEN) ? burst[i] : 1'b0;
      check("hdr_ready", bus.slave_ready, 1);
      tick();
    end
    bus.master_valid = 1'b0;
  endtask

  task automatic write_txn(input logic [11:0] addr, input logic [11:0] burst, input bit stall);
    int n = (burst == 0) ? 1 : int'(burst);
    send_header(1'b1, addr, burst, stall);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < DATA_LEN; b++) begin
        if (stall && $urandom_range(0, 3) == 0) begin
          bus.master_valid = 1'b0;
          tick();
        end
        bus.master_valid = 1'b1;
        bus.rx_data      = wbuf[w][b];
        check("wr_ready", bus.slave_ready, 1);
        tick();
      end
      model[(int'(addr) + w) % DEPTH] = wbuf[w];
    end
    bus.master_valid = 1'b0;
    check("wr_end_busy", bus.busy, 0);
    bus.write_en = 1'b0;
  endtask

  // mode 0: master_ready always 1; mode 1: pattern 1,0,0,1; mode 2: random
  task automatic read_txn(input logic [11:0] addr, input logic [11:0] burst,
                          input int delay, input int mode, input bit stall);
    int n = (burst == 0) ? 1 : int'(burst);
    int cnt = 0;
    int splits = 0;
    logic [3:0] pat = 4'b1001;
    bus.slave_delay = 6'(delay);
    send_header(1'b0, addr, burst, stall);
    bus.slave_delay  = 6'($urandom_range(0, 63));
    bus.master_ready = 1'b0;
    while (!bus.slave_valid && cnt < 200) begin
      if (bus.split_en) splits++;
      cnt++;
      tick();
    end
    check("rd_latency", cnt, delay + 2);
    check("rd_split_cycles", splits, (delay >= SPLIT_TH) ? delay + 1 : 0);
    if (cnt >= 200) begin
      bus.read_en = 1'b0;
      tick();
      return;
    end
    for (int w = 0; w < n; w++) begin
      logic [7:0] got_w = '0;
      int  bits = 0;
      int  guard = 0;
      bit  prev_hold = 0;
      logic held = 1'b0;
      bit  rdy;
      while (bits < DATA_LEN && guard < 100) begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = pat[guard % 4];
          default: rdy = ($urandom_range(0, 2) != 0);
        endcase
        bus.master_ready = rdy;
        check("rd_valid", bus.slave_valid, 1);
        if (prev_hold) check("rd_hold", bus.tx_data, held);
        if (rdy) begin
          got_w[bits] = bus.tx_data;
          bits++;
          prev_hold = 0;
        end else begin
          prev_hold = 1;
          held = bus.tx_data;
        end
        tick();
        guard++;
      end
      bus.master_ready = 1'b0;
      check("rd_word", got_w, model[(int'(addr) + w) % DEPTH]);
      check("rd_gap_valid", bus.slave_valid, 0);
      if (w < n - 1) tick();
    end
    check("rd_end_busy", bus.busy, 0);
    bus.read_en = 1'b0;
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_ready", bus.slave_ready, 1);
    check("rst_valid", bus.slave_valid, 0);
    check("rst_tx",    bus.tx_data, 0);
    check("rst_split", bus.split_en, 0);
    check("rst_busy",  bus.busy, 0);
    reset = 1'b0;
    tick();

    // single word, minimum latency
    wbuf[0] = 8'hA5;
    write_txn(12'h005, 12'd1, 1'b0);
    read_txn(12'h005, 12'd1, 0, 0, 1'b0);

    // burst of three wrapping past the top of memory
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    write_txn(12'hFFF, 12'd3, 1'b0);
    read_txn(12'hFFF, 12'd3, 3, 0, 1'b0);
    read_txn(12'h000, 12'd1, 0, 0, 1'b0);
    check("wrap_word0", model[0], 8'h22);

    // split above threshold, none below, master_ready throttling
    read_txn(12'h005, 12'd1, 20, 0, 1'b0);
    read_txn(12'h005, 12'd1, 5, 0, 1'b0);
    read_txn(12'hFFF, 12'd3, 0, 1, 1'b0);

    // write aborted after four data bits leaves the target word untouched
    send_header(1'b1, 12'h005, 12'd1, 1'b0);
    for (int b = 0; b < 4; b++) begin
      bus.master_valid = 1'b1;
      bus.rx_data      = 1'b0;
      tick();
    end
    bus.master_valid = 1'b0;
    bus.write_en     = 1'b0;
    tick();
    check("abort_busy",  bus.busy, 0);
    check("abort_ready", bus.slave_ready, 1);
    read_txn(12'h005, 12'd1, 0, 0, 1'b0);

    // both enables high in IDLE is ignored
    bus.read_en = 1'b1; bus.write_en = 1'b1; bus.master_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("both_en_busy", bus.busy, 0);
    end
    idle_inputs();
    tick();

    // abort during a split wait clears split_en
    bus.slave_delay = 6'd30;
    send_header(1'b0, 12'h005, 12'd1, 1'b0);
    tick();
    check("wait_split", bus.split_en, 1);
    bus.read_en = 1'b0;
    tick();
    check("abort_split", bus.split_en, 0);
    check("abort_wait_busy", bus.busy, 0);

    // reset in the middle of a read word
    bus.slave_delay = 6'd0;
    send_header(1'b0, 12'hFFF, 12'd1, 1'b0);
    tick();
    tick();
    check("pre_rst_valid", bus.slave_valid, 1);
    bus.master_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", bus.slave_valid, 0);
    check("mid_rst_split", bus.split_en, 0);
    check("mid_rst_ready", bus.slave_ready, 1);
    check("mid_rst_busy",  bus.busy, 0);
    reset = 1'b0;
    idle_inputs();
    tick();
    read_txn(12'hFFF, 12'd1, 0, 0, 1'b0);

    // randomized write/read pairs
    for (int t = 0; t < 40; t++) begin
      logic [11:0] a = 12'($urandom);
      logic [11:0] bl = 12'($urandom_range(0, 4));
      int nw = (bl == 0) ? 1 : int'(bl);
      for (int w = 0; w < nw; w++) wbuf[w] = 8'($urandom);
      write_txn(a, bl, 1'b1);
      read_txn(a, bl, $urandom_range(0, 24), $urandom_range(0, 2), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule

// File: doc/bram_slave_split.md
Name: bram_slave_split

Overview:
- Parametrised block-RAM bus slave, the successor to the fixed 4k RAM slave.
- Connects to one slave port of the bus interconnect, using the serial 1-bit address/data/burst lanes, LSB first.
- Adds configurable memory depth, burst transfers with address wrap, a programmable read delay, and split-transaction signalling so the arbiter can release the bus during long read delays.

Parameters:
- ADDR_LEN, 12, serial address bits per transaction; low clog2(MEM_DEPTH) bits index memory.
- DATA_LEN, 8, bits per data word.
- BURST_LEN, 12, serial burst-count bits; must be <= ADDR_LEN.
- MEM_DEPTH, 4096, words of storage; power of two.
- SPLIT_EN, 1, 1 = split signalling enabled.
- SPLIT_THRESHOLD, 8, minimum slave_delay that triggers split.

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high
- slave_delay  in  6  read wait cycles; sampled on entry to WAIT
- read_en  in  1  read transaction select
- write_en  in  1  write transaction select
- master_valid  in  1  master drives a valid serial bit this cycle
- master_ready  in  1  master accepts a tx_data bit this cycle
- rx_address  in  1  serial address bit
- rx_data  in  1  serial write data bit
- rx_burst  in  1  serial burst-count bit
- slave_ready  out  1  slave accepts serial bits
- slave_valid  out  1  tx_data carries a valid read bit
- tx_data  out  1  serial read data bit
- split_en  out  1  slave requests split (bus may be released)
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high) forces IDLE and sets: slave_ready=1, slave_valid=0, tx_data=0, split_en=0, busy=0, all counters and shift registers=0. Memory contents are retained. Reset mid-transaction aborts it with no partial write.
- States: IDLE, ADDR, WDATA, WAIT, RFETCH, RDATA.
- IDLE:
  - slave_ready=1.
  - If master_valid && (read_en XOR write_en): capture address bit 0 and burst bit 0, set bit count=1, go to ADDR.
  - If read_en && write_en are both high, the request is ignored and the block stays in IDLE.
- ADDR:
  - slave_ready=1.
  - Each master_valid cycle shifts rx_address in. The first BURST_LEN valid cycles also shift rx_burst in.
  - master_valid low holds the state (stall).
  - After ADDR_LEN bits: write goes to WDATA; read goes to WAIT with delay counter = slave_delay.
- Burst word count = burst field value; 0 is treated as 1. Maximum 2^BURST_LEN-1.
- WDATA:
  - slave_ready=1.
  - Shift rx_data on each master_valid cycle.
  - On the DATA_LEN-th bit, write the assembled word to mem[addr] on the same clock edge, then addr=(addr+1) mod MEM_DEPTH and words_left--.
  - When words_left reaches 0, go to IDLE.
- WAIT:
  - slave_ready=0. Count down the delay.
  - split_en=1 for the whole of WAIT iff SPLIT_EN && slave_delay>=SPLIT_THRESHOLD; otherwise 0.
  - Counter==0 goes to RFETCH. Delay 0 gives one WAIT cycle.
- RFETCH:
  - One cycle for the synchronous BRAM read; load the shift register.
  - slave_valid=0; split_en=0.
- RDATA:
  - slave_valid=1; tx_data = shift register LSB.
  - Shift only on cycles with master_ready=1; otherwise hold tx_data stable.
  - After DATA_LEN accepted bits: addr wraps mod MEM_DEPTH and words_left--. If nonzero, go to RFETCH; else go to IDLE.
  - slave_valid drops in the cycle after the last accepted bit.
- Abort: in any non-IDLE state, read_en==0 && write_en==0 returns the block to IDLE next cycle. A partially received word is discarded, and split_en and slave_valid clear.
- Minimum read latency: ADDR_LEN address cycles, then 1 WAIT cycle, then 1 RFETCH cycle, then the first valid bit.

Test Plan:
- Write burst=1, addr 0x005, data 0xA5; then read addr 0x005, delay 0, master_ready=1 -> tx_data bits 1,0,1,0,0,1,0,1 over 8 slave_valid cycles; slave_valid rises 2 cycles after the last address bit.
- Write burst=3 at addr 0xFFF, data 0x11/0x22/0x33 -> mem[0xFFF]=0x11, mem[0x000]=0x22, mem[0x001]=0x33; a burst-3 read from 0xFFF returns the same sequence, with slave_valid low exactly one cycle between words.
- Read with slave_delay=20, SPLIT_EN=1, threshold 8 -> split_en high for 21 cycles, then low. With slave_delay=5: split_en stays 0 and slave_valid rises after 6 WAIT cycles plus RFETCH.
- During RDATA, toggle master_ready 1,0,0,1... -> tx_data holds its value on ready-low cycles; all 8 bits are still delivered in order; no word loss.
- Write aborted after 4 data bits (read_en=write_en=0) -> IDLE next cycle, busy=0, target word unchanged. read_en=write_en=1 in IDLE -> no state change.
- Assert reset mid-RDATA -> next cycle: slave_valid=0, split_en=0, slave_ready=1, busy=0. A later read of the same address returns the pre-reset data.
